decoy_rng_packer: RTL and testbench

- Downstream consumer of the decoy stage's 2-bit amplitude-RNG symbol stream (rng_a, qualified by rd_en_4) in the clk200 domain.
- Aligns to the first PPS rising edge after enable and packs symbols LSB-first into DATA_WIDTH-bit words.
- Buffers the words in a small FIFO and presents them on a valid/ready stream toward the DDR write path.
- Reports overflow and drop statistics for debug and AXI-lite readback.

---
 rtl/decoy_rng_packer.sv | 173 +++++++++++++++++
 tb/tb_decoy_rng_packer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/decoy_rng_packer.sv
`default_nettype none
// ============================================================================
// Module   : decoy_rng_packer
// Brief    : PPS-aligned packer of 2-bit decoy RNG symbols into words, with a
//            FWFT output FIFO and drop statistics. Optional arm header word
//            enabled by DECOY_RNG_PACK_HEADER_EN (requires DATA_WIDTH = 32).
// Revision : 1.0 - initial release
// ============================================================================
module decoy_rng_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk200,
    input  logic                  rstn_200,
    input  logic                  en_i,
    input  logic                  pps_i,
    input  logic                  rd_en_4,
    input  logic [1:0]            rng_a,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  overflow_o,
    output logic [CNT_WIDTH-1:0]  drop_cnt_o,
    output logic [CNT_WIDTH-1:0]  word_cnt_o,
    output logic [1:0]            state_o
);
    localparam int SYMS  = DATA_WIDTH / 2;
    localparam int IDX_W = $clog2(SYMS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2,
        PACK = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic                  pps_r;
    logic [IDX_W-1:0]      sym_idx;
    logic [DATA_WIDTH-1:0] pack_reg, pack_next, push_data;
    logic                  push_req;
    logic                  arm_entry, pps_rise, capture, last_sym;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic                  full, pop, push_ok, push_drop;

`ifdef DECOY_RNG_PACK_HEADER_EN
    logic [7:0]            arm_seq;
`endif

    assign arm_entry = (state == IDLE) && en_i;
    assign pps_rise  = (state == WAIT) && en_i && !pps_r && pps_i;
    assign capture   = (state == PACK) && en_i && rd_en_4;
    assign last_sym  = (sym_idx == IDX_W'(SYMS - 1));

    always_comb begin
        state_nxt = state;
        if (!en_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARM;
                ARM:     if (!pps_i) state_nxt = WAIT;
                WAIT:    if (pps_rise) state_nxt = PACK;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        pack_next = pack_reg;
        pack_next[{sym_idx, 1'b0} +: 2] = rng_a;
    end

    always_ff @(posedge clk200) begin
        if (!rstn_200) begin
            state     <= IDLE;
            pps_r     <= 1'b0;
            sym_idx   <= '0;
            pack_reg  <= '0;
            push_req  <= 1'b0;
            push_data <= '0;
        end else begin
            state    <= state_nxt;
            pps_r    <= (state == WAIT) ? pps_i : 1'b0;
            push_req <= 1'b0;
            // Leaving PACK (or never in it) discards any partial word.
            if (state == PACK && en_i) begin
                if (capture) begin
                    pack_reg <= pack_next;
                    if (last_sym) begin
                        push_req  <= 1'b1;
                        push_data <= pack_next;
                        sym_idx   <= '0;
                    end else begin
                        sym_idx <= sym_idx + IDX_W'(1);
                    end
                end
            end else begin
                sym_idx  <= '0;
                pack_reg <= '0;
            end
`ifdef DECOY_RNG_PACK_HEADER_EN
            if (pps_rise) begin
                push_req  <= 1'b1;
                push_data <= {16'hDEC0, 8'h00, arm_seq};
            end
`endif
        end
    end

`ifdef DECOY_RNG_PACK_HEADER_EN
    always_ff @(posedge clk200) begin
        if (!rstn_200) begin
            arm_seq <= '0;
        end else if (arm_entry) begin
            arm_seq <= arm_seq + 8'd1;
        end
    end
`endif

    // A full FIFO still accepts a push when a pop frees a slot that cycle.
    assign full      = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign m_tvalid  = (count != '0);
    assign pop       = m_tvalid && m_tready;
    assign push_ok   = push_req && (!full || pop);
    assign push_drop = push_req && full && !pop;
    assign m_tdata   = m_tvalid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk200) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk200) begin
        if (!rstn_200) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk200) begin
        if (!rstn_200 || arm_entry) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
            word_cnt_o <= '0;
        end else begin
            if (push_ok) word_cnt_o <= word_cnt_o + CNT_WIDTH'(1);
            if (push_drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_WIDTH'(1);
            end
        end
    end

    assign state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_decoy_rng_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_decoy_rng_packer
// Brief    : Scoreboard bench for decoy_rng_packer (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoy_rng_packer;
`ifdef DECOY_RNG_PACK_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        clk200 = 1'b0;
    logic        rstn_200, en_i, pps_i, rd_en_4, m_tready;
    logic [1:0]  rng_a;
    logic [31:0] m_tdata;
    logic        m_tvalid, overflow_o;
    logic [15:0] drop_cnt_o, word_cnt_o;
    logic [1:0]  state_o;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          arms   = 0;
    logic [31:0] exp_q[$];
    logic        hold_prev = 1'b0;
    logic [31:0] hold_data = '0;

    decoy_rng_packer #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .CNT_WIDTH(16)) dut (
        .clk200(clk200), .rstn_200(rstn_200), .en_i(en_i), .pps_i(pps_i),
        .rd_en_4(rd_en_4), .rng_a(rng_a), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
        .word_cnt_o(word_cnt_o), .state_o(state_o)
    );

    always #2.5 clk200 = ~clk200;

    // Monitor: pops the scoreboard on every accepted beat, checks hold stability.
    always @(negedge clk200) begin
        logic [31:0] e;
        if (m_tvalid && !m_tready && hold_prev) begin
            n_vec++;
            if (m_tdata !== hold_data) begin
                n_miss++;
                $display("FAIL hold_stable: got %h, expected %h", m_tdata, hold_data);
            end
        end
        hold_prev = m_tvalid && !m_tready;
        hold_data = m_tdata;
        if (m_tvalid && m_tready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_word: got %h, expected no word", m_tdata);
            end else begin
                e = exp_q.pop_front();
                if (m_tdata !== e) begin
                    n_miss++;
                    $display("FAIL stream_word: got %h, expected %h", m_tdata, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk200);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [1:0] s);
        rd_en_4 = 1'b1;
        rng_a   = s;
        tick();
        rd_en_4 = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 16; k++) strobe(w[2*k +: 2]);
    endtask

    // From IDLE: arm, wait for PPS low, then raise PPS. Optional junk strobes
    // are held high through arm, wait and the edge-detect cycle.
    task automatic arm_pps(input logic early);
        en_i  = 1'b1;
        pps_i = 1'b0;
        if (early) begin
            rd_en_4 = 1'b1;
            rng_a   = 2'b01;
        end
        tick();
        arms++;
        check("state_arm", {30'd0, state_o}, 32'd1);
        check("arm_clears", {15'd0, overflow_o, drop_cnt_o}, 32'd0);
        tick();
        check("state_wait", {30'd0, state_o}, 32'd2);
        pps_i = 1'b1;
        tick();
        rd_en_4 = 1'b0;
        check("state_pack", {30'd0, state_o}, 32'd3);
        if (HDR != 0) exp_q.push_back({16'hDEC0, 8'h00, 8'(arms)});
    endtask

    task automatic disarm();
        en_i = 1'b0;
        tick();
        check("state_idle", {30'd0, state_o}, 32'd0);
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
        tick();
        tick();
        check("drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words [11];
        rstn_200 = 1'b0; en_i = 1'b0; pps_i = 1'b0; rd_en_4 = 1'b0;
        rng_a = 2'b00; m_tready = 1'b1;
        repeat (3) tick();
        check("rst_state", {30'd0, state_o}, 32'd0);
        check("rst_valid", {31'd0, m_tvalid}, 32'd0);
        check("rst_data", m_tdata, 32'd0);
        check("rst_cnts", {15'd0, overflow_o, drop_cnt_o}, 32'd0);
        check("rst_wcnt", {16'd0, word_cnt_o}, 32'd0);
        rstn_200 = 1'b1;
        tick();

        // Basic packing and output latency.
        arm_pps(1'b0);
        tick(); tick(); tick();
        exp_q.push_back(32'hE4E4E4E4);
        for (int k = 0; k < 16; k++) strobe(2'(k % 4));
        check("valid_lat_n1", {31'd0, m_tvalid}, 32'd0);
        tick();
        check("valid_lat_n2", {31'd0, m_tvalid}, 32'd1);
        check("wcnt_one", {16'd0, word_cnt_o}, 32'(1 + HDR));
        drain(50);

        // Early strobes and edge-detect-cycle strobe are ignored.
        disarm();
        arm_pps(1'b1);
        exp_q.push_back(32'hFFFFFFFF);
        send_word(32'hFFFFFFFF);
        drain(50);
        check("wcnt_rearm", {16'd0, word_cnt_o}, 32'(1 + HDR));

        // Overflow with a stalled consumer.
        disarm();
        m_tready = 1'b0;
        arm_pps(1'b0);
        for (int i = 0; i < 11; i++) words[i] = 32'h1000_0000 + 32'(i * 32'h0101_0101);
        for (int i = 0; i < 10; i++) begin
            if (i + HDR < 8) exp_q.push_back(words[i]);
            send_word(words[i]);
        end
        tick(); tick();
        check("ovf_flag", {31'd0, overflow_o}, 32'd1);
        check("ovf_drops", {16'd0, drop_cnt_o}, 32'(2 + HDR));
        check("ovf_wcnt", {16'd0, word_cnt_o}, 32'd8);
        check("ovf_front", m_tdata, exp_q[0]);

        // Push and pop in the same cycle while full.
        exp_q.push_back(words[10]);
        send_word(words[10]);
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        tick();
        check("full_pp_drops", {16'd0, drop_cnt_o}, 32'(2 + HDR));
        check("full_pp_wcnt", {16'd0, word_cnt_o}, 32'd9);
        m_tready = 1'b1;
        drain(100);
        check("empty_after", {31'd0, m_tvalid}, 32'd0);

        // Partial word discarded on disable.
        disarm();
        arm_pps(1'b0);
        for (int k = 0; k < 7; k++) strobe(2'b11);
        disarm();
        tick();
        arm_pps(1'b0);
        exp_q.push_back(32'h55555555);
        send_word(32'h55555555);
        drain(50);
        check("partial_wcnt", {16'd0, word_cnt_o}, 32'(1 + HDR));
        check("partial_ovf", {15'd0, overflow_o, drop_cnt_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
